arc4_sched: RTL and testbench

- Top-level sequencer for the ARC4 datapath.
- On one start request it runs the three stages strictly in order, init (S[i]=i), ksa, then prga, each through its en/rdy handshake.
- Gives the single-port 256x8 S memory to exactly one stage at a time by muxing that stage's addr/wrdata/wren onto the memory.
- Sits between the top-level wrapper and the init/ksa/prga instances.

---
 rtl/arc4_pkg.sv | 32 +++
 rtl/arc4_sched_if.sv | 40 ++++
 rtl/arc4_mem_mux.sv | 47 ++++
 rtl/arc4_sched.sv | 118 +++++++++++
 tb/tb_arc4_sched.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arc4_pkg.sv
// Shared types and defaults for the ARC4 stage sequencer.
// Define ARC4_SCHED_TIMEOUT_EN to include the StErr state.
package arc4_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StGoInit,
    StRunInit,
    StGoKsa,
    StRunKsa,
    StGoPrga,
    StRunPrga
`ifdef ARC4_SCHED_TIMEOUT_EN
    , StErr
`endif
  } sched_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_KSA,
    OWN_PRGA
  } owner_t;

  function automatic logic is_go(sched_state_t s);
    return (s == StGoInit) || (s == StGoKsa) || (s == StGoPrga);
  endfunction

endpackage

// File: rtl/arc4_sched_if.sv
// Handshake and S-memory bus between the sequencer, its stages and the wrapper.
interface arc4_sched_if
  import arc4_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              en;
  logic              rdy;
  owner_t            stage;
  logic              err;
  logic              init_en, ksa_en, prga_en;
  logic              init_rdy, ksa_rdy, prga_rdy;
  logic [ADDR_W-1:0] init_addr, ksa_addr, prga_addr;
  logic [DATA_W-1:0] init_wrdata, ksa_wrdata, prga_wrdata;
  logic              init_wren, ksa_wren, prga_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wrdata;
  logic              mem_wren;

  modport master (
    output en, init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, stage, err, init_en, ksa_en, prga_en,
    input  mem_addr, mem_wrdata, mem_wren
  );

  modport slave (
    input  en, init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, stage, err, init_en, ksa_en, prga_en,
    output mem_addr, mem_wrdata, mem_wren
  );

endinterface

// File: rtl/arc4_mem_mux.sv
// Combinational S-memory port mux; only the owning stage reaches the memory.
module arc4_mem_mux
  import arc4_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  owner_t            owner_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [DATA_W-1:0] init_wrdata_i,
  input  logic              init_wren_i,
  input  logic [ADDR_W-1:0] ksa_addr_i,
  input  logic [DATA_W-1:0] ksa_wrdata_i,
  input  logic              ksa_wren_i,
  input  logic [ADDR_W-1:0] prga_addr_i,
  input  logic [DATA_W-1:0] prga_wrdata_i,
  input  logic              prga_wren_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wrdata_o,
  output logic              mem_wren_o
);

  always_comb begin
    mem_addr_o   = '0;
    mem_wrdata_o = '0;
    mem_wren_o   = 1'b0;
    unique case (owner_i)
      OWN_NONE: ;
      OWN_INIT: begin
        mem_addr_o   = init_addr_i;
        mem_wrdata_o = init_wrdata_i;
        mem_wren_o   = init_wren_i;
      end
      OWN_KSA: begin
        mem_addr_o   = ksa_addr_i;
        mem_wrdata_o = ksa_wrdata_i;
        mem_wren_o   = ksa_wren_i;
      end
      OWN_PRGA: begin
        mem_addr_o   = prga_addr_i;
        mem_wrdata_o = prga_wrdata_i;
        mem_wren_o   = prga_wren_i;
      end
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 sequencer: runs init, ksa, prga in order and grants the S memory to one stage at a time.
// Define ARC4_SCHED_TIMEOUT_EN to add a per-stage busy timeout with a sticky error state.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  arc4_sched_if.slave bus
);

  sched_state_t state_q, state_d;
  logic         first_q, first_d;
  owner_t       owner;
  logic         timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.init_en  = 1'b0;
    bus.ksa_en   = 1'b0;
    bus.prga_en  = 1'b0;
    unique case (state_q)
      StIdle:    if (bus.en) state_d = StGoInit;
      StGoInit: begin
        bus.init_en = bus.init_rdy;
        if (bus.init_rdy) state_d = StRunInit;
      end
      // A stage still shows its pre-start rdy during the first run cycle.
      StRunInit: if (!first_q && bus.init_rdy) state_d = StGoKsa;
      StGoKsa: begin
        bus.ksa_en = bus.ksa_rdy;
        if (bus.ksa_rdy) state_d = StRunKsa;
      end
      StRunKsa:  if (!first_q && bus.ksa_rdy) state_d = StGoPrga;
      StGoPrga: begin
        bus.prga_en = bus.prga_rdy;
        if (bus.prga_rdy) state_d = StRunPrga;
      end
      StRunPrga: if (!first_q && bus.prga_rdy) state_d = StIdle;
`ifdef ARC4_SCHED_TIMEOUT_EN
      StErr:     state_d = StErr;
`endif
      default:   state_d = StIdle;
    endcase
    if (timeout) state_d = sched_state_t'(StIdle + 3'd7);
  end

  assign first_d = is_go(state_q) && (state_d != state_q);

  always_comb begin
    unique case (state_q)
      StGoInit, StRunInit: owner = OWN_INIT;
      StGoKsa, StRunKsa:   owner = OWN_KSA;
      StGoPrga, StRunPrga: owner = OWN_PRGA;
      default:             owner = OWN_NONE;
    endcase
  end

  assign bus.rdy   = (state_q == StIdle);
  assign bus.stage = owner;

`ifdef ARC4_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (owner != OWN_NONE) && (cnt_q + CntW'(1) == CntW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (is_go(state_d) && (state_d != state_q)) cnt_d = '0;
    else if (owner != OWN_NONE)                 cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.err = (state_q == StErr);
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  arc4_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_mux (
    .owner_i       (owner),
    .init_addr_i   (bus.init_addr),
    .init_wrdata_i (bus.init_wrdata),
    .init_wren_i   (bus.init_wren),
    .ksa_addr_i    (bus.ksa_addr),
    .ksa_wrdata_i  (bus.ksa_wrdata),
    .ksa_wren_i    (bus.ksa_wren),
    .prga_addr_i   (bus.prga_addr),
    .prga_wrdata_i (bus.prga_wrdata),
    .prga_wren_i   (bus.prga_wren),
    .mem_addr_o    (bus.mem_addr),
    .mem_wrdata_o  (bus.mem_wrdata),
    .mem_wren_o    (bus.mem_wren)
  );

endmodule

// File: tb/tb_arc4_sched.sv
// Scoreboard bench for arc4_sched with stub init/ksa/prga stages.
module tb_arc4_sched;
  import arc4_pkg::*;

`ifdef ARC4_SCHED_TIMEOUT_EN
  localparam int TimeoutCyc = 100;
`else
  localparam int TimeoutCyc = 4096;
`endif

  typedef struct {
    int kind;
    int cyc;
    int stage;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n1 = 256;
  int   n2 = 768;
  int   n3 = 512;
  logic ksa_hold = 1'b0;
  logic ksa_glitch = 1'b0;
  int   init_cnt, ksa_cnt, prga_cnt;
  int   init_wr = 0;
  int   exp_init_wr = 0;
  int   st1_bad = 0;
  int   st2_bad = 0;
  int   st3_bad = 0;
  int   idle_bad = 0;
  logic rdy_prev = 1'b1;
  logic err_prev = 1'b0;
  ev_t  exp_q[$];

  arc4_sched_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  arc4_sched #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (TimeoutCyc)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub stages: rdy low for n cycles after their en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                init_cnt <= 0;
    else if (bus.init_en)      init_cnt <= n1;
    else if (init_cnt != 0)    init_cnt <= init_cnt - 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ksa_cnt <= 0;
    else if (bus.ksa_en)       ksa_cnt <= n2;
    else if (ksa_cnt != 0)     ksa_cnt <= ksa_cnt - 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                prga_cnt <= 0;
    else if (bus.prga_en)      prga_cnt <= n3;
    else if (prga_cnt != 0)    prga_cnt <= prga_cnt - 1;
  end

  assign bus.init_rdy    = (init_cnt == 0);
  assign bus.init_addr   = 8'(n1 - init_cnt);
  assign bus.init_wrdata = 8'(n1 - init_cnt);
  assign bus.init_wren   = (init_cnt != 0);
  assign bus.ksa_rdy     = ((ksa_cnt == 0) || ksa_glitch) && !ksa_hold;
  assign bus.ksa_addr    = 8'hFF;
  assign bus.ksa_wrdata  = 8'hA5;
  assign bus.ksa_wren    = 1'b1;
  assign bus.prga_rdy    = (prga_cnt == 0);
  assign bus.prga_addr   = 8'h33;
  assign bus.prga_wrdata = 8'h5A;
  assign bus.prga_wren   = (prga_cnt != 0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int stage);
    ev_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.stage = stage;
    exp_q.push_back(e);
  endtask

  // Events: 1 init_en, 2 ksa_en, 3 prga_en, 4 rdy rise, 5 err rise.
  task automatic push_run(input int s, input int h);
    push_ev(1, s, 1);
    push_ev(2, s + n1 + 2 + h, 2);
    push_ev(3, s + n1 + n2 + 4 + h, 3);
    push_ev(4, s + n1 + n2 + n3 + 6 + h, 0);
    exp_init_wr += n1;
  endtask

  task automatic start(output int s);
    s = cyc + 1;
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic see_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: got kind=%0d cyc=%0d, required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.stage != int'(bus.stage)) begin
        failures++;
        $display("FAIL event: got kind=%0d cyc=%0d stage=%0d required kind=%0d cyc=%0d stage=%0d",
                 kind, cyc, int'(bus.stage), e.kind, e.cyc, e.stage);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.init_en) see_ev(1);
      if (bus.ksa_en) see_ev(2);
      if (bus.prga_en) see_ev(3);
      if (bus.rdy && !rdy_prev) see_ev(4);
      if (bus.err && !err_prev) see_ev(5);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing event: got none by cyc=%0d required kind=%0d at cyc=%0d",
                 cyc, exp_q[0].kind, exp_q[0].cyc);
        exp_q.delete(0);
      end
      if (bus.stage == OWN_NONE) begin
        if (bus.mem_wren || bus.mem_addr != 8'h00 || bus.mem_wrdata != 8'h00) idle_bad++;
`ifndef ARC4_SCHED_TIMEOUT_EN
        if (!bus.rdy || bus.err) idle_bad++;
`endif
      end else begin
        if (bus.rdy) idle_bad++;
        if (bus.stage == OWN_INIT) begin
          if (bus.mem_wren != bus.init_wren) st1_bad++;
          else if (bus.mem_wren) begin
            if (bus.mem_addr != 8'(init_wr) || bus.mem_wrdata != 8'(init_wr)) st1_bad++;
            init_wr++;
          end
        end else if (bus.stage == OWN_KSA) begin
          if (bus.mem_addr != 8'hFF || bus.mem_wrdata != 8'hA5 || !bus.mem_wren) st2_bad++;
        end else begin
          if (bus.mem_addr != 8'h33 || bus.mem_wrdata != 8'h5A ||
              bus.mem_wren != (prga_cnt != 0)) st3_bad++;
        end
      end
    end
    rdy_prev = bus.rdy;
    err_prev = bus.err;
  end

  initial begin
    int s, sd, se;
    bus.en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdy", int'(bus.rdy), 1);
    chk("reset stage", int'(bus.stage), 0);
    chk("reset err", int'(bus.err), 0);
    chk("reset init_en", int'(bus.init_en), 0);
    chk("reset ksa_en", int'(bus.ksa_en), 0);
    chk("reset prga_en", int'(bus.prga_en), 0);
    chk("reset mem_wren", int'(bus.mem_wren), 0);
    chk("reset mem_addr", int'(bus.mem_addr), 0);
    chk("reset mem_wrdata", int'(bus.mem_wrdata), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef ARC4_SCHED_TIMEOUT_EN
    n1       = 20;
    ksa_hold = 1'b1;
    start(s);
    push_ev(1, s, 1);
    push_ev(5, s + n1 + 2 + TimeoutCyc, 0);
    exp_init_wr += n1;
    wait_cyc(s + n1 + 2 + TimeoutCyc + 50);
    chk("err sticky", int'(bus.err), 1);
    chk("err rdy", int'(bus.rdy), 0);
    chk("err stage", int'(bus.stage), 0);
    chk("err mem_wren", int'(bus.mem_wren), 0);
    rst_n = 1'b0;
    #1;
    chk("err cleared by reset", int'(bus.err), 0);
    chk("rdy after err reset", int'(bus.rdy), 1);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ksa_hold = 1'b0;
    wait_cyc(cyc + 2);
`else
    // Plain run with an en pulse mid-ksa that must be ignored.
    start(s);
    push_run(s, 0);
    wait_cyc(s + n1 + 2 + 100);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    wait_cyc(s + n1 + n2 + n3 + 8);
    chk("run A idle rdy", int'(bus.rdy), 1);

    // ksa_rdy held low for 10 cycles after GO_KSA entry.
    ksa_hold = 1'b1;
    start(s);
    push_run(s, 10);
    wait_cyc(s + n1 + 2 + 10);
    ksa_hold = 1'b0;
    wait_cyc(s + n1 + n2 + n3 + 6 + 10 + 4);

    // Reset mid-prga.
    start(s);
    push_run(s, 0);
    wait_cyc(s + n1 + n2 + 4 + 50);
    chk("pre-reset stage", int'(bus.stage), 3);
    chk("pre-reset mem_wren", int'(bus.mem_wren), 1);
    rst_n = 1'b0;
    #1;
    chk("abort rdy", int'(bus.rdy), 1);
    chk("abort stage", int'(bus.stage), 0);
    chk("abort mem_wren", int'(bus.mem_wren), 0);
    chk("abort prga_en", int'(bus.prga_en), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // en held across completion, plus a ksa_rdy glitch in the first RUN_KSA cycle.
    bus.en = 1'b1;
    sd = cyc + 1;
    push_run(sd, 0);
    wait_cyc(sd + n1 + 3);
    ksa_glitch = 1'b1;
    wait_cyc(sd + n1 + 4);
    ksa_glitch = 1'b0;
    se = sd + n1 + n2 + n3 + 6 + 1;
    push_run(se, 0);
    wait_cyc(se);
    bus.en = 1'b0;
    wait_cyc(se + n1 + n2 + n3 + 6 + 4);
    chk("final rdy", int'(bus.rdy), 1);
`endif
    chk("scoreboard drained", exp_q.size(), 0);
    chk("init writes", init_wr, exp_init_wr);
    chk("init ownership errors", st1_bad, 0);
    chk("ksa ownership errors", st2_bad, 0);
    chk("prga ownership errors", st3_bad, 0);
    chk("idle bus errors", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
